// File: rtl/lc3_pkg.sv
// rtl/lc3_pkg.sv - condition-code types, constants and bus-to-flags helper
package lc3_pkg;

  typedef logic [2:0] cc_t;

  localparam cc_t CC_N     = 3'b100;
  localparam cc_t CC_Z     = 3'b010;
  localparam cc_t CC_P     = 3'b001;
  localparam cc_t CC_RESET = CC_Z;

  localparam int WORD_MAX = 64;

  // Callers zero-extend their word into WORD_MAX bits and pass its real width.
  function automatic cc_t cc_from_word(input logic [WORD_MAX-1:0] value, input int width);
    if (value == '0)
      return CC_Z;
    if (value[6'(width - 1)])
      return CC_N;
    return CC_P;
  endfunction

endpackage

// File: rtl/nzp_cc_unit_if.sv
// rtl/nzp_cc_unit_if.sv - bus/strobe/status bundle between control logic and the cc unit
interface nzp_cc_unit_if #(
  parameter int DATA_W = 16,
  parameter int DEPTH  = 4
);
  localparam int PTR_W = $clog2(DEPTH + 1);

  logic [DATA_W-1:0] bus;
  logic              load_nzp;
  logic              cc_push;
  logic              cc_pop;
  logic [2:0]        br_nzp;
  logic              err_clr;
  logic              n;
  logic              z;
  logic              p;
  logic              br_taken;
  logic [PTR_W-1:0]  depth;
  logic              full;
  logic              empty;
  logic              ovf;
  logic              unf;

  modport master (
    output bus, load_nzp, cc_push, cc_pop, br_nzp, err_clr,
    input  n, z, p, br_taken, depth, full, empty, ovf, unf
  );

  modport slave (
    input  bus, load_nzp, cc_push, cc_pop, br_nzp, err_clr,
    output n, z, p, br_taken, depth, full, empty, ovf, unf
  );
endinterface

// File: rtl/nzp_cc_stack.sv
// rtl/nzp_cc_stack.sv - DEPTH x 3 LIFO of saved flags with occupancy and sticky ovf/unf
module nzp_cc_stack
  import lc3_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         push,
  input  logic                         pop,
  input  logic                         err_clr,
  input  cc_t                          push_data,
  output cc_t                          top_data,
  output logic                         pop_ok,
  output logic [$clog2(DEPTH+1)-1:0]   depth,
  output logic                         full,
  output logic                         empty,
  output logic                         ovf,
  output logic                         unf
);
  localparam int PTR_W = $clog2(DEPTH + 1);
  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  cc_t              mem [DEPTH];
  logic [PTR_W-1:0] cnt;
  logic             push_ok;
  logic             ovf_set;
  logic             unf_set;

  assign full  = (cnt == PTR_W'(DEPTH));
  assign empty = (cnt == '0);
  assign depth = cnt;

  // A simultaneous push and pop is an illegal request: neither happens, both errors latch.
  assign push_ok = push && !pop && !full;
  assign pop_ok  = pop && !push && !empty;
  assign ovf_set = push && (pop || full);
  assign unf_set = pop && (push || empty);

  assign top_data = mem[IDX_W'(cnt - 1'b1)];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt <= '0;
      ovf <= 1'b0;
      unf <= 1'b0;
    end else begin
      if (push_ok)
        cnt <= cnt + 1'b1;
      else if (pop_ok)
        cnt <= cnt - 1'b1;
      ovf <= ovf_set | (ovf & ~err_clr);
      unf <= unf_set | (unf & ~err_clr);
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok)
      mem[IDX_W'(cnt)] <= push_data;
  end

endmodule

// File: rtl/nzp_cc_unit.sv
// rtl/nzp_cc_unit.sv - N/Z/P flag register with save stack and BR evaluation
// CC_BYPASS_EN: br_taken evaluates the flags about to be written instead of the registered ones.
module nzp_cc_unit
  import lc3_pkg::*;
#(
  parameter int DATA_W = 16,
  parameter int DEPTH  = 4
) (
  input  logic            clk,
  input  logic            reset,
  nzp_cc_unit_if.slave    cc
);
  cc_t  flags;
  cc_t  next_flags;
  cc_t  load_cc;
  cc_t  top_data;
  logic pop_ok;

  nzp_cc_stack #(.DEPTH(DEPTH)) u_stack (
    .clk       (clk),
    .reset     (reset),
    .push      (cc.cc_push),
    .pop       (cc.cc_pop),
    .err_clr   (cc.err_clr),
    .push_data (flags),
    .top_data  (top_data),
    .pop_ok    (pop_ok),
    .depth     (cc.depth),
    .full      (cc.full),
    .empty     (cc.empty),
    .ovf       (cc.ovf),
    .unf       (cc.unf)
  );

  assign load_cc = cc_from_word(WORD_MAX'(cc.bus), DATA_W);

  // A restore from RTI outranks a load issued in the same cycle.
  always_comb begin
    next_flags = flags;
    if (pop_ok)
      next_flags = top_data;
    else if (cc.load_nzp)
      next_flags = load_cc;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      flags <= CC_RESET;
    else
      flags <= next_flags;
  end

  assign cc.n = flags[2];
  assign cc.z = flags[1];
  assign cc.p = flags[0];

`ifdef CC_BYPASS_EN
  assign cc.br_taken = |(cc.br_nzp & next_flags);
`else
  assign cc.br_taken = |(cc.br_nzp & flags);
`endif

endmodule

// File: tb/tb_nzp_cc_unit.sv
// tb/tb_nzp_cc_unit.sv - self-checking bench for nzp_cc_unit against a queue-based reference model
module tb_nzp_cc_unit;
  localparam int DATA_W = 16;
  localparam int DEPTH  = 4;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  nzp_cc_unit_if #(.DATA_W(DATA_W), .DEPTH(DEPTH)) cc_if ();

  nzp_cc_unit #(.DATA_W(DATA_W), .DEPTH(DEPTH)) dut (
    .clk   (clk),
    .reset (reset),
    .cc    (cc_if)
  );

  int checks = 0;
  int errors = 0;

  logic [2:0] m_flags;
  logic [2:0] m_q[$];
  bit         m_ovf;
  bit         m_unf;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [2:0] word_cc(input logic [DATA_W-1:0] w);
    if (w == 0) return 3'b010;
    if (int'(w) >= (1 << (DATA_W - 1))) return 3'b100;
    return 3'b001;
  endfunction

  function automatic logic [2:0] model_next(input bit ld, input logic [DATA_W-1:0] b,
                                            input bit pu, input bit po);
    if (po && !pu && m_q.size() > 0) return m_q[m_q.size() - 1];
    if (ld) return word_cc(b);
    return m_flags;
  endfunction

  task automatic model_reset();
    m_flags = 3'b010;
    m_q.delete();
    m_ovf = 0;
    m_unf = 0;
  endtask

  task automatic model_update(input bit ld, input logic [DATA_W-1:0] b,
                              input bit pu, input bit po, input bit clr);
    logic [2:0] nf;
    bit so, su;
    nf = model_next(ld, b, pu, po);
    so = pu && (po || m_q.size() == DEPTH);
    su = po && (pu || m_q.size() == 0);
    if (pu && !po && m_q.size() < DEPTH) m_q.push_back(m_flags);
    if (po && !pu && m_q.size() > 0) void'(m_q.pop_back());
    m_flags = nf;
    m_ovf = so ? 1'b1 : (clr ? 1'b0 : m_ovf);
    m_unf = su ? 1'b1 : (clr ? 1'b0 : m_unf);
  endtask

  task automatic check_state(input string tag);
    check({tag, ".nzp"},   {cc_if.n, cc_if.z, cc_if.p}, m_flags);
    check({tag, ".depth"}, cc_if.depth, m_q.size());
    check({tag, ".full"},  cc_if.full, m_q.size() == DEPTH);
    check({tag, ".empty"}, cc_if.empty, m_q.size() == 0);
    check({tag, ".ovf"},   cc_if.ovf, m_ovf);
    check({tag, ".unf"},   cc_if.unf, m_unf);
  endtask

  task automatic step(input string tag, input bit ld, input logic [DATA_W-1:0] b,
                      input bit pu, input bit po, input logic [2:0] br, input bit clr);
    logic [2:0] nf;
    bit exp_br;
    cc_if.load_nzp = ld;
    cc_if.bus      = b;
    cc_if.cc_push  = pu;
    cc_if.cc_pop   = po;
    cc_if.br_nzp   = br;
    cc_if.err_clr  = clr;
    #1;
    nf = model_next(ld, b, pu, po);
`ifdef CC_BYPASS_EN
    exp_br = |(br & nf);
`else
    exp_br = |(br & m_flags);
`endif
    check({tag, ".br_taken"}, cc_if.br_taken, exp_br);
    @(posedge clk);
    model_update(ld, b, pu, po, clr);
    #1;
    check_state(tag);
    cc_if.load_nzp = 0;
    cc_if.cc_push  = 0;
    cc_if.cc_pop   = 0;
    cc_if.err_clr  = 0;
  endtask

  initial begin
    reset = 1'b1;
    cc_if.bus = '0;
    cc_if.load_nzp = 0;
    cc_if.cc_push = 0;
    cc_if.cc_pop = 0;
    cc_if.br_nzp = 3'b000;
    cc_if.err_clr = 0;
    model_reset();
    #12;
    check_state("reset");
    reset = 1'b0;

    // Loads
    step("ld_8000", 1, 16'h8000, 0, 0, 3'b000, 0);
    step("ld_0000", 1, 16'h0000, 0, 0, 3'b000, 0);
    step("ld_7fff", 1, 16'h7FFF, 0, 0, 3'b000, 0);
    step("ld_ffff", 1, 16'hFFFF, 0, 0, 3'b000, 0);

    // Branch mask with flags = 001
    step("ld_0001", 1, 16'h0001, 0, 0, 3'b000, 0);
    step("br_001", 0, 16'h0000, 0, 0, 3'b001, 0);
    step("br_110", 0, 16'h0000, 0, 0, 3'b110, 0);
    step("br_000", 0, 16'h0000, 0, 0, 3'b000, 0);
    step("br_111", 0, 16'h0000, 0, 0, 3'b111, 0);

    // Nested save/restore
    step("nest_ld1", 1, 16'h8000, 0, 0, 3'b100, 0);
    step("nest_push1", 0, 16'h0000, 1, 0, 3'b000, 0);
    step("nest_ld2", 1, 16'h0005, 0, 0, 3'b001, 0);
    step("nest_push2", 0, 16'h0000, 1, 0, 3'b000, 0);
    step("nest_ld3", 1, 16'h0000, 0, 0, 3'b010, 0);
    step("nest_pop1", 0, 16'h0000, 0, 1, 3'b001, 0);
    step("nest_pop2", 0, 16'h0000, 0, 1, 3'b100, 0);

    // Overflow then underflow; pushes carry loads so each entry differs
    step("ovf_ld", 1, 16'hC000, 0, 0, 3'b000, 0);
    step("ovf_push1", 1, 16'h0000, 1, 0, 3'b000, 0);
    step("ovf_push2", 1, 16'h1234, 1, 0, 3'b000, 0);
    step("ovf_push3", 1, 16'h9999, 1, 0, 3'b000, 0);
    step("ovf_push4", 1, 16'h0000, 1, 0, 3'b000, 0);
    step("ovf_push5", 1, 16'h0042, 1, 0, 3'b000, 0);
    for (int i = 0; i < 5; i++)
      step($sformatf("unf_pop%0d", i), 0, 16'h0000, 0, 1, 3'b111, 0);
    step("err_clr", 0, 16'h0000, 0, 0, 3'b000, 1);

    // Simultaneous events
    step("sim_ld", 1, 16'h8001, 0, 0, 3'b000, 0);
    step("sim_push_ld", 1, 16'h0000, 1, 0, 3'b000, 0);
    step("sim_pop_ld", 1, 16'h0007, 0, 1, 3'b100, 0);
    step("sim_push_a", 0, 16'h0000, 1, 0, 3'b000, 0);
    step("sim_push_pop", 1, 16'h0003, 1, 1, 3'b001, 0);
    step("sim_clr_set", 0, 16'h0000, 1, 1, 3'b000, 1);
    step("sim_clr", 0, 16'h0000, 0, 0, 3'b000, 1);

    // Async reset with three entries saved
    step("ar_push2", 1, 16'h8000, 1, 0, 3'b000, 0);
    step("ar_push3", 1, 16'h0009, 1, 0, 3'b000, 0);
    check("ar_depth3", cc_if.depth, 3);
    cc_if.load_nzp = 1;
    cc_if.bus = 16'hF000;
    reset = 1'b1;
    #1;
    model_reset();
    check_state("async_reset");
    cc_if.load_nzp = 0;
    #1;
    reset = 1'b0;

    // Load-to-branch in the same cycle from flags 010
    step("bypass", 1, 16'h0003, 0, 0, 3'b001, 0);

    // Randomized traffic
    for (int i = 0; i < 400; i++) begin
      logic [DATA_W-1:0] b;
      int sel;
      sel = $urandom_range(0, 3);
      b = (sel == 0) ? '0 : DATA_W'($urandom);
      step($sformatf("rnd%0d", i), 1'($urandom_range(0, 1)), b,
           $urandom_range(0, 3) == 0, $urandom_range(0, 3) == 0,
           3'($urandom), $urandom_range(0, 7) == 0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/nzp_cc_unit.md
Name: nzp_cc_unit

Overview:
Parametrised successor to the LC-3 condition-code register. It holds the N/Z/P flags, which are always one-hot. Flags are loaded from the datapath bus using a signed interpretation. A DEPTH-entry save/restore stack preserves the flags across nested interrupts and RTI. The block also evaluates the BR instruction's nzp mask. It sits between the bus, the control FSM (load/push/pop strobes) and the PC-select logic (br_taken).

Parameters:
DATA_W, 16, bus width in bits; bit DATA_W-1 is the sign bit.
DEPTH, 4, number of save-stack entries (>=1).
PTR_W, $clog2(DEPTH+1), occupancy counter width (derived; not overridden).

Ports:
clk  in  1  system clock, rising edge.
reset  in  1  asynchronous, active-high reset.
bus  in  DATA_W  datapath bus value to evaluate.
load_nzp  in  1  load flags from bus this cycle.
cc_push  in  1  save current flags onto stack (interrupt entry).
cc_pop  in  1  restore flags from stack top (RTI).
br_nzp  in  3  BR instruction mask {n,z,p}.
err_clr  in  1  clear sticky error flags.
n  out  1  negative flag (registered).
z  out  1  zero flag (registered).
p  out  1  positive flag (registered).
br_taken  out  1  |(br_nzp & {n,z,p}); combinational.
depth  out  PTR_W  current stack occupancy.
full  out  1  depth == DEPTH.
empty  out  1  depth == 0.
ovf  out  1  sticky: push attempted while full.
unf  out  1  sticky: pop attempted while empty.

Behaviour:
- Reset (async, immediate): n=0, z=1, p=0; depth=0; ovf=unf=0; stack contents don't-care. Flags one-hot from reset onward.
- Flag evaluation on load: n = bus[DATA_W-1]; z = (bus == 0); p = !n && !z. Exactly one set.
- Flag latency: flags update on the clk edge after the strobe is sampled; visible one cycle later.
- Flag priority per cycle: valid pop > load_nzp > hold.
- Valid pop, depth>0: flags <= stack[depth-1]; depth decrements; a simultaneous load_nzp is discarded.
- Push, depth<DEPTH: stack[depth] <= current (pre-edge) flags; depth increments. A simultaneous load_nzp still updates flags, so the old flags are saved and the new ones loaded.
- Push while full: stack and depth unchanged; ovf <= 1. A load in the same cycle still applies.
- Pop while empty: flags and depth unchanged, except that a load in the same cycle applies; unf <= 1.
- Push and pop in the same cycle: both ignored; depth and stack unchanged; ovf <= 1 and unf <= 1. load_nzp applies normally.
- Error flags: err_clr clears ovf/unf. If a new error occurs in the same cycle, set wins over clear.
- br_taken: combinational AND-reduce-OR of br_nzp with the registered flags. br_nzp=000 gives 0; br_nzp=111 gives 1.
- Mid-operation reset: reset asserted at any time returns to the reset state within the same cycle, with no wait for clk; pending strobes are lost.
- Status outputs: full, empty and depth derive from the counter only; no separate state.

Optional Feature:
CC_BYPASS_EN
- Defined: br_taken uses the flags that will be written at the next edge, so a BR can follow a flag-setting op with zero bubble:
  - valid pop: restored flags;
  - load_nzp: bus-derived flags;
  - otherwise: registered flags.
- Undefined: br_taken uses registered flags only (one-cycle load-to-branch latency). Registered n/z/p outputs are identical in both builds.

Decomposition:
- Shared package lc3_pkg:
  - typedef cc_t (3-bit {n,z,p});
  - constants CC_N=3'b100, CC_Z=3'b010, CC_P=3'b001 and CC_RESET=CC_Z;
  - function cc_from_word(DATA_W value) returning cc_t.
- One sub-module, nzp_cc_stack: DEPTH x 3 LIFO with push/pop/full/empty/depth and ovf/unf.
- The top level contains the flag register, priority mux and br_taken logic.

Test Plan:
- Reset then loads: release reset, check n/z/p=010. Load bus=16'h8000 -> 100; bus=16'h0000 -> 010; bus=16'h7FFF -> 001; bus=16'hFFFF -> 100.
- Branch mask: flags=001; br_nzp=001 -> br_taken=1; br_nzp=110 -> 0; 000 -> 0; 111 -> 1.
- Nested save/restore: load 8000 (100), push, load 0005 (001), push, load 0000 (010). Pop -> 001, depth=1. Pop -> 100, depth=0, empty=1.
- Overflow/underflow with DEPTH=4: five pushes -> depth=4, full=1, ovf=1, stack intact. Then five pops -> last pop gives unf=1, flags equal first-saved value. err_clr -> ovf=unf=0.
- Simultaneous events:
  - push+load bus=0000 with flags 100: stack top=100, flags=010.
  - pop+load: restored value wins.
  - push+pop: depth unchanged, ovf=unf=1.
- Async reset mid-stack: depth=3, assert reset between edges -> flags 010, depth=0 immediately, before next clk. With CC_BYPASS_EN: load bus=0003 and br_nzp=001 in the same cycle -> br_taken=1 that cycle (0 without the macro when prior flags are 010).
